// File: rtl/fdd_pkg.sv
// Shared definitions for the Disk II track loader and the future write-back block.
package fdd_pkg;

    localparam int unsigned TRACK_BYTES = 6656;
    localparam int unsigned NUM_TRACKS  = 35;
    localparam int unsigned TRACK_W     = 6;
    localparam int unsigned IDX_W       = 13;

    localparam logic [TRACK_W-1:0] LOADED_NONE = 6'h3F;
    localparam logic [TRACK_W-1:0] LAST_TRACK  = TRACK_W'(NUM_TRACKS - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(TRACK_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_FETCH,
        ST_WRITE,
        ST_ABORT
    } fdd_state_e;

    // Head positions past the last track read the last track.
    function automatic logic [TRACK_W-1:0] clamp_track(input logic [TRACK_W-1:0] t);
        return (t > LAST_TRACK) ? LAST_TRACK : t;
    endfunction

endpackage

// File: rtl/fdd_track_base.sv
// Byte address of the first nibble of a track in the image store.
// 6656 = 4096 + 2048 + 512, so the product is a three-term shift-add.
module fdd_track_base
    import fdd_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 18,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
    input  logic [TRACK_W-1:0] t_i,
    output logic [ADDR_W-1:0]  base_o
);

    logic [ADDR_W-1:0] t_ext;

    // Shift-add track offset plus image base.
    always_comb begin
        t_ext  = ADDR_W'(t_i);
        base_o = (t_ext << 12) + (t_ext << 11) + (t_ext << 9) + BASE_ADDR;
    end

endmodule

// File: rtl/fdd140_track_loader.sv
// Fills the Disk II track RAM from the image store whenever the head
// settles on a track that is not already buffered.
module fdd140_track_loader
    import fdd_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 18,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
    parameter int unsigned       SETTLE_CYCLES = 4096
)(
    input  logic              clk,
    input  logic              RESET,
    input  logic [5:0]        TRACK,
    input  logic              image_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic [12:0]       ram_write_addr,
    output logic [7:0]        ram_di,
    output logic              ram_we,
    output logic              busy,
    output logic [5:0]        loaded_track
);

    localparam int unsigned      CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    fdd_state_e         state_q,  state_d;
    logic [TRACK_W-1:0] tgt_q,    tgt_d;
    logic [TRACK_W-1:0] loaded_q, loaded_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic [IDX_W-1:0]   waddr_q,  waddr_d;
    logic [7:0]         wdata_q,  wdata_d;

    logic [TRACK_W-1:0] track_c;
    logic [ADDR_W-1:0]  base_w;
    logic               change;
    logic               leave_load;

    assign track_c = clamp_track(TRACK);
    assign change  = (track_c != tgt_q) || !image_valid;

    fdd_track_base #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_base (
        .t_i    (tgt_q),
        .base_o (base_w)
    );

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            tgt_q    <= '0;
            loaded_q <= LOADED_NONE;
            cnt_q    <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            loaded_q <= loaded_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state logic; handshake outputs are decoded from the current state
    // so that RESET drops mem_req and ram_we without waiting for a clock.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        loaded_d   = loaded_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        mem_req    = 1'b0;
        ram_we     = 1'b0;
        leave_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (image_valid && (track_c != loaded_q)) begin
                    tgt_d   = track_c;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!image_valid) begin
                    state_d = ST_IDLE;
                end else if (track_c != tgt_q) begin
                    tgt_d = track_c;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    idx_d    = '0;
                    addr_d   = base_w;
                    loaded_d = LOADED_NONE;
                    state_d  = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (change) begin
                        leave_load = 1'b1;
                    end else begin
                        wdata_d = mem_data;
                        waddr_d = idx_q;
                        state_d = ST_WRITE;
                    end
                end else if (change) begin
                    // tgt is frozen here so mem_addr holds until the ack arrives.
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    leave_load = 1'b1;
                end
            end
            ST_WRITE: begin
                ram_we = 1'b1;
                if (change) begin
                    leave_load = 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    loaded_d = tgt_q;
                    state_d  = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    addr_d  = base_w + ADDR_W'(idx_q + 1'b1);
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Common exit from an interrupted load: restart settling on the new
        // head position, or park in IDLE if the image went away.
        if (leave_load) begin
            if (!image_valid) begin
                state_d = ST_IDLE;
            end else begin
                tgt_d   = track_c;
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign mem_addr       = addr_q;
    assign ram_write_addr = waddr_q;
    assign ram_di         = wdata_q;
    assign loaded_track   = loaded_q;

endmodule

// File: tb/tb_fdd140_track_loader.sv
// Directed bench for the Disk II track loader with a behavioural image store.
module tb_fdd140_track_loader;

    localparam int unsigned SETTLE = 64;

    logic        clk = 1'b0;
    logic        RESET;
    logic [5:0]  TRACK;
    logic        image_valid;
    logic [17:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic        resp_ack;
    logic        stray_ack;
    logic [7:0]  mem_data;
    logic [12:0] ram_write_addr;
    logic [7:0]  ram_di;
    logic        ram_we;
    logic        busy;
    logic [5:0]  loaded_track;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned ack_lat     = 0;

    int unsigned mon_base, exp_idx, req_idx;
    int unsigned n_we, n_bad_we, n_req, n_bad_req, n_unstable;
    int unsigned first_req_addr, last_req_addr;
    logic        req_prev  = 1'b0;
    logic [17:0] addr_prev = '0;

    always #5 clk = ~clk;

    assign mem_ack = resp_ack | stray_ack;

    fdd140_track_loader #(
        .ADDR_W        (18),
        .BASE_ADDR     (18'd0),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk            (clk),
        .RESET          (RESET),
        .TRACK          (TRACK),
        .image_valid    (image_valid),
        .mem_addr       (mem_addr),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data),
        .ram_write_addr (ram_write_addr),
        .ram_di         (ram_di),
        .ram_we         (ram_we),
        .busy           (busy),
        .loaded_track   (loaded_track)
    );

    function automatic logic [7:0] img_byte(input int unsigned a);
        return 8'(a ^ (a >> 8) ^ (a >> 16) ^ 32'h5A);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mon_clear(input int unsigned base);
        mon_base   = base;
        exp_idx    = 0;
        req_idx    = 0;
        n_we       = 0;
        n_bad_we   = 0;
        n_req      = 0;
        n_bad_req  = 0;
        n_unstable = 0;
        first_req_addr = 32'hFFFF_FFFF;
        last_req_addr  = 32'hFFFF_FFFF;
    endtask

    task automatic wait_loaded(input logic [5:0] t, input int budget, input string tag);
        int i = 0;
        while (loaded_track !== t && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, 32'(loaded_track), 32'(t));
    endtask

    task automatic wait_we(input int unsigned n, input int budget, input string tag);
        int i = 0;
        while (n_we < n && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, 32'(n_we >= n), 32'd1);
    endtask

    task automatic wait_req(input int budget, input string tag);
        int i = 0;
        while (mem_req !== 1'b1 && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, 32'(mem_req), 32'd1);
    endtask

    // Image store: one-cycle ack ack_lat+1 cycles after req is first seen.
    initial begin
        int unsigned w;
        w        = 0;
        resp_ack = 1'b0;
        mem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_ack) begin
                resp_ack = 1'b0;
                w = 0;
            end else if (mem_req === 1'b1) begin
                if (w >= ack_lat) begin
                    resp_ack = 1'b1;
                    mem_data = img_byte(32'(mem_addr));
                    w = 0;
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    // Track RAM and request-port observer.
    initial begin
        forever begin
            @(negedge clk);
            if (ram_we === 1'b1) begin
                if (ram_write_addr !== 13'(exp_idx) || ram_di !== img_byte(mon_base + exp_idx))
                    n_bad_we++;
                n_we++;
                exp_idx++;
            end
            if (mem_req === 1'b1 && !req_prev) begin
                if (n_req == 0) first_req_addr = 32'(mem_addr);
                last_req_addr = 32'(mem_addr);
                if (32'(mem_addr) != mon_base + req_idx) n_bad_req++;
                n_req++;
                req_idx++;
            end
            if (mem_req === 1'b1 && req_prev && mem_addr !== addr_prev) n_unstable++;
            req_prev  = (mem_req === 1'b1);
            addr_prev = mem_addr;
        end
    end

    initial begin
        int unsigned snap;
        RESET       = 1'b1;
        TRACK       = 6'd0;
        image_valid = 1'b0;
        stray_ack   = 1'b0;
        ack_lat     = 2;
        mon_clear(0);
        tick(3);

        // Reset state
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_ram_waddr", 32'(ram_write_addr), 0);
        check("rst_ram_di", 32'(ram_di), 0);
        check("rst_loaded", 32'(loaded_track), 32'h3F);

        // Full load of track 0, ack three cycles after req
        RESET = 1'b0;
        tick(2);
        check("t1_idle_no_image", 32'(busy), 0);
        image_valid = 1'b1;
        tick(SETTLE);
        check("t1_settle_busy", 32'(busy), 1);
        check("t1_settle_no_req", 32'(mem_req), 0);
        tick(1);
        check("t1_first_req", 32'(mem_req), 1);
        check("t1_first_addr", 32'(mem_addr), 0);
        wait_loaded(6'd0, 40000, "t1_loaded");
        check("t1_n_we", n_we, 6656);
        check("t1_bad_we", n_bad_we, 0);
        check("t1_n_req", n_req, 6656);
        check("t1_bad_req", n_bad_req, 0);
        check("t1_last_addr", last_req_addr, 6655);
        check("t1_unstable", n_unstable, 0);
        check("t1_busy_done", 32'(busy), 0);

        // Track 17 full load
        mon_clear(17 * 6656);
        ack_lat = 0;
        TRACK = 6'd17;
        tick(5);
        check("t2_keep_loaded", 32'(loaded_track), 0);
        check("t2_busy", 32'(busy), 1);
        wait_loaded(6'd17, 20000, "t2_loaded");
        check("t2_first_addr", first_req_addr, 113152);
        check("t2_last_addr", last_req_addr, 119807);
        check("t2_n_we", n_we, 6656);
        check("t2_bad_we", n_bad_we, 0);
        check("t2_bad_req", n_bad_req, 0);
        check("t2_busy_done", 32'(busy), 0);

        // Short steps 5,6 then 7: only track 7 is ever requested
        mon_clear(7 * 6656);
        TRACK = 6'd5;
        tick(30);
        TRACK = 6'd6;
        tick(30);
        TRACK = 6'd7;
        tick(30);
        check("t3_no_early_req", n_req, 0);
        wait_we(20, 2000, "t3_writes");
        check("t3_first_addr", first_req_addr, 46592);
        check("t3_bad_req", n_bad_req, 0);
        check("t3_bad_we", n_bad_we, 0);
        check("t3_loaded_none", 32'(loaded_track), 32'h3F);

        // Load track 3, switch to 4 while request for idx 100 is pending
        TRACK = 6'd3;
        tick(6);
        check("t4_abort_req_low", 32'(mem_req), 0);
        mon_clear(3 * 6656);
        ack_lat = 8;
        wait_we(100, 2000, "t4_100_writes");
        wait_req(50, "t4_req_100");
        TRACK = 6'd4;
        tick(20);
        check("t4_no_we_on_abort", n_we, 100);
        check("t4_req_dropped", 32'(mem_req), 0);
        check("t4_busy_settle", 32'(busy), 1);
        check("t4_n_req", n_req, 101);
        check("t4_pending_addr", last_req_addr, 20068);
        check("t4_addr_stable", n_unstable, 0);
        check("t4_bad_we", n_bad_we, 0);
        mon_clear(4 * 6656);
        ack_lat = 0;
        wait_we(10, 400, "t4_reload");
        check("t4_reload_first", first_req_addr, 26624);
        check("t4_reload_bad_we", n_bad_we, 0);
        check("t4_reload_bad_req", n_bad_req, 0);

        // Asynchronous reset during a fetch
        ack_lat = 5;
        wait_req(50, "t5_in_fetch");
        RESET = 1'b1;
        #1;
        check("t5_req_async", 32'(mem_req), 0);
        check("t5_we_async", 32'(ram_we), 0);
        check("t5_loaded_async", 32'(loaded_track), 32'h3F);
        check("t5_busy_async", 32'(busy), 0);
        tick(2);
        RESET = 1'b0;
        mon_clear(4 * 6656);
        ack_lat = 0;
        wait_we(5, 400, "t5_reload");
        check("t5_reload_first", first_req_addr, 26624);
        check("t5_reload_bad_we", n_bad_we, 0);

        // Unmount mid-load, move the head, remount on the same track
        image_valid = 1'b0;
        tick(5);
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_idle_req", 32'(mem_req), 0);
        check("t6_loaded_none", 32'(loaded_track), 32'h3F);
        mon_clear(0);
        TRACK = 6'd9;
        tick(100);
        TRACK = 6'd20;
        tick(100);
        TRACK = 6'd50;
        tick(100);
        check("t6_no_req", n_req, 0);
        check("t6_no_busy", 32'(busy), 0);
        TRACK = 6'd4;
        image_valid = 1'b1;
        mon_clear(4 * 6656);
        tick(2);
        check("t6_remount_busy", 32'(busy), 1);
        wait_we(5, 400, "t6_remount_load");
        check("t6_remount_first", first_req_addr, 26624);

        // Head past the last track loads track 34
        TRACK = 6'd50;
        tick(6);
        mon_clear(34 * 6656);
        wait_loaded(6'd34, 20000, "t7_loaded_34");
        check("t7_first_addr", first_req_addr, 226304);
        check("t7_last_addr", last_req_addr, 232959);
        check("t7_n_we", n_we, 6656);
        check("t7_bad_we", n_bad_we, 0);

        // Stray ack while idle, and a clamped track equal to the buffer
        snap = n_we;
        stray_ack = 1'b1;
        tick(1);
        stray_ack = 1'b0;
        tick(3);
        check("t8_stray_no_we", n_we, snap);
        check("t8_stray_no_req", 32'(mem_req), 0);
        check("t8_stray_idle", 32'(busy), 0);
        TRACK = 6'd63;
        tick(100);
        check("t8_clamp_no_busy", 32'(busy), 0);
        check("t8_clamp_no_req", n_req, 6656);
        check("t8_clamp_loaded", 32'(loaded_track), 34);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
